// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch stage.
package fetch_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    RST_HOLD,
    FETCH,
    DRAIN,
    HOLD
  } fetch_state_t;

  // Sequential instruction stride in bytes.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Instructions are word aligned: the low two bits of a loaded PC are forced to zero.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_register.sv
// Loadable program-counter register with asynchronous active-low reset.
module pc_register #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  logic [XLEN-1:0] q_q;
  logic [XLEN-1:0] q_d;

  // Next value: take the new PC on load, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VECTOR;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter and instruction fetch stage. Holds the PC, fetches one
// instruction at a time over a req/ack memory port and hands it to decode
// over valid/ready. Only XLEN = 32 is supported.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] next_pc,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            misaligned
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            misaligned_q, misaligned_d;
  logic            pc_load;
  logic [XLEN-1:0] pc_q;

  pc_register #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_register (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (align_pc(next_pc)),
    .q     (pc_q)
  );

  // Next-state logic. A flush always reloads the PC (except right after reset);
  // an outstanding request that is not acked in the flush cycle is finished in
  // DRAIN at the old address, which is parked in drain_addr. A drain completes
  // on ack even if another flush arrives in the same cycle.
  always_comb begin
    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc_load      = 1'b0;
    case (state_q)
      RST_HOLD: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (flush) begin
          pc_load = 1'b1;
          if (!imem_ack) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (flush) begin
          pc_load = 1'b1;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (flush || instr_ready) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = RST_HOLD;
      end
    endcase
    misaligned_d = pc_load ? (|next_pc[1:0]) : misaligned_q;
  end

  // State, drain address, captured instruction and misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_HOLD;
      drain_addr_q <= '0;
      instr_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign misaligned  = misaligned_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + PC_STEP;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios followed by
// randomized flush/ack/ready traffic, compared against a flag-based reference model.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_fetch_stage #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .misaligned  (misaligned)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  // Reference model: what the stage is doing, as independent flags.
  logic        m_started, m_fetching, m_draining, m_holding, m_mis;
  logic [31:0] m_pc, m_drain_addr, m_instr;

  task automatic model_reset();
    m_started    = 1'b0;
    m_fetching   = 1'b0;
    m_draining   = 1'b0;
    m_holding    = 1'b0;
    m_mis        = 1'b0;
    m_pc         = 32'h0;
    m_drain_addr = 32'h0;
    m_instr      = 32'h0;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic exp_req;
    exp_req = m_fetching || m_draining;
    check_eq({ctx, ".req"}, imem_req, exp_req);
    if (exp_req) check_eq({ctx, ".addr"}, imem_addr, m_draining ? m_drain_addr : m_pc);
    check_eq({ctx, ".pc"}, pc, m_pc);
    check_eq({ctx, ".pc4"}, pc_plus4, m_pc + 32'd4);
    check_eq({ctx, ".instr"}, instr, m_instr);
    check_eq({ctx, ".valid"}, instr_valid, m_holding);
    check_eq({ctx, ".mis"}, misaligned, m_mis);
  endtask

  // Advance the model over one rising edge with the given inputs.
  task automatic model_step(input logic f, input logic a, input logic r, input logic [31:0] np);
    logic [31:0] old_pc;
    logic        load;
    old_pc = m_pc;
    load   = 1'b0;
    if (!m_started) begin
      m_started  = 1'b1;
      m_fetching = 1'b1;
    end else if (m_holding) begin
      if (f || r) begin
        load       = 1'b1;
        m_holding  = 1'b0;
        m_fetching = 1'b1;
      end
    end else if (m_fetching) begin
      if (f) begin
        load = 1'b1;
        if (!a) begin
          m_fetching   = 1'b0;
          m_draining   = 1'b1;
          m_drain_addr = old_pc;
        end
      end else if (a) begin
        m_instr    = mem_word(old_pc);
        m_fetching = 1'b0;
        m_holding  = 1'b1;
      end
    end else if (m_draining) begin
      if (f) load = 1'b1;
      if (a) begin
        m_draining = 1'b0;
        m_fetching = 1'b1;
      end
    end
    if (load) begin
      m_pc  = {np[31:2], 2'b00};
      m_mis = |np[1:0];
    end
  endtask

  // One clock: drive inputs at the falling edge, step the model at the rising
  // edge, check all outputs at the next falling edge.
  task automatic cycle(input string ctx, input logic f, input logic a, input logic r,
                       input logic [31:0] np);
    flush       = f;
    imem_ack    = a;
    instr_ready = r;
    next_pc     = np;
    if (m_holding && r && !f) check_eq({ctx, ".accept"}, instr, mem_word(m_pc));
    @(posedge clk);
    model_step(f, a, r, np);
    @(negedge clk);
    check_outputs(ctx);
    $display("[TB] %s f=%0b a=%0b r=%0b np=%h -> req=%0b addr=%h pc=%h v=%0b instr=%h mis=%0b",
             ctx, f, a, r, np, imem_req, imem_addr, pc, instr_valid, instr, misaligned);
  endtask

  initial begin
    logic [31:0] seq_q[$];
    logic [31:0] np;
    logic        f, a, r;

    rst_n       = 1'b0;
    flush       = 1'b0;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    next_pc     = 32'h0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait memory, ready high, sequential next PC.
    for (int i = 0; i < 6; i++) begin
      cycle("seq", 1'b0, 1'b1, 1'b1, m_pc + 32'd4);
      if (imem_req) seq_q.push_back(imem_addr);
    end
    check_eq("seq.count", seq_q.size(), 3);
    for (int i = 0; i < 3 && i < seq_q.size(); i++)
      check_eq("seq.addr", seq_q[i], 32'(i * 4));

    // Decode stalls for 4 cycles while holding, then accepts.
    for (int i = 0; i < 4; i++) cycle("stall", 1'b0, 1'b0, 1'b0, $urandom);
    cycle("stall_acc", 1'b0, 1'b0, 1'b1, m_pc + 32'd4);

    // Memory acks after 3 wait cycles.
    for (int i = 0; i < 3; i++) cycle("wait", 1'b0, 1'b0, 1'b1, 32'h0);
    cycle("wait_ack", 1'b0, 1'b1, 1'b1, 32'h0);

    // Flush from HOLD to a misaligned target.
    cycle("flush_hold", 1'b1, 1'b0, 1'b1, 32'h0000_0042);
    check_eq("flush_hold.pc", pc, 32'h40);
    check_eq("flush_hold.addr", imem_addr, 32'h40);

    // Flush during FETCH without ack: old address drained, then 0x100 fetched.
    cycle("flush_fetch", 1'b1, 1'b0, 1'b1, 32'h100);
    cycle("drain", 1'b0, 1'b0, 1'b1, 32'h0);
    cycle("drain_ack", 1'b0, 1'b1, 1'b1, 32'h0);
    check_eq("drain.next_addr", imem_addr, 32'h100);
    cycle("post_drain", 1'b0, 1'b1, 1'b0, 32'h0);

    // PC at the top of the address space wraps its increment to zero.
    cycle("wrap", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    check_eq("wrap.pc4", pc_plus4, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      f  = ($urandom_range(0, 9) == 0);
      a  = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 3) != 0);
      np = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
      if ($urandom_range(0, 49) == 0) np = 32'hFFFF_FFFC;
      cycle("rand", f, a, r, np);
    end

    // Reach a fetch with the request outstanding, then reset asynchronously.
    for (int i = 0; i < 10 && !m_fetching; i++)
      cycle("to_fetch", 1'b0, m_draining, 1'b1, m_pc + 32'd4);
    cycle("fetch_wait", 1'b0, 1'b0, 1'b1, m_pc + 32'd4);
    check_eq("async.pre_req", imem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async");
    imem_ack = 1'b1;
    @(negedge clk);
    check_outputs("async_hold");
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    cycle("restart", 1'b0, 1'b0, 1'b1, 32'h4);
    check_eq("restart.addr", imem_addr, 32'h0);
    cycle("restart_ack", 1'b0, 1'b1, 1'b1, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
